// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: synthetic 640x480@60 timing and test-pattern source.
// A core-clock divider produces a pixel tick. The h/v counters advance on
// each tick. All pixel outputs are decoded from the next position and are
// registered together on the tick edge.
module vga_pattern_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        I_CLK_100,
  input  logic        I_RST,
  input  logic        I_EN,
  input  logic [1:0]  I_PATTERN,
  output logic [23:0] O_PIX_DATA,
  output logic        O_VSYNC,
  output logic        O_HSYNC,
  output logic        O_DE,
  output logic        O_PCLK,
  output logic [9:0]  O_X,
  output logic [9:0]  O_Y,
  output logic        O_FRAME_START
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] D_HALF = DW'(CLK_DIV / 2);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic SYNC_ON  = 1'(SYNC_POL);
  localparam logic SYNC_OFF = ~SYNC_ON;

  logic [DW-1:0] d, d_nxt;
  logic          tick;
  // first: no pixel presented yet since reset/enable, so the next one is (0,0)
  logic          first;
  logic [1:0]    pat_q, pat_nxt;
  logic [9:0]    nh, nv;
  logic          origin, de_nxt, hs_nxt, vs_nxt;
  logic [2:0]    bar;
  logic [23:0]   pix_nxt;

  assign tick  = I_EN && (d == D_LAST);
  assign d_nxt = tick ? '0 : d + 1'b1;

  // next raster position; O_X/O_Y hold the one currently presented
  always_comb begin
    nh = '0;
    nv = '0;
    if (!first) begin
      if (O_X == H_LAST) begin
        nh = '0;
        nv = (O_Y == V_LAST) ? '0 : O_Y + 10'd1;
      end else begin
        nh = O_X + 10'd1;
        nv = O_Y;
      end
    end
  end

  assign origin  = (nh == '0) && (nv == '0);
  // a new select takes effect from the first pixel of a frame, never mid-frame
  assign pat_nxt = origin ? I_PATTERN : pat_q;
  assign de_nxt  = (nh < H_ACT) && (nv < V_ACT);
  assign hs_nxt  = (nh >= HS_BEG && nh <= HS_END) ? SYNC_ON : SYNC_OFF;
  assign vs_nxt  = (nv >= VS_BEG && nv <= VS_END) ? SYNC_ON : SYNC_OFF;
  assign bar     = 3'(nh / 10'd80);

  // pattern decode for the next pixel, blanked outside the active region
  always_comb begin
    pix_nxt = '0;
    if (de_nxt) begin
      case (pat_nxt)
        2'd0: begin
          case (bar)
            3'd0:    pix_nxt = 24'hFFFFFF;
            3'd1:    pix_nxt = 24'hFFFF00;
            3'd2:    pix_nxt = 24'h00FFFF;
            3'd3:    pix_nxt = 24'h00FF00;
            3'd4:    pix_nxt = 24'hFF00FF;
            3'd5:    pix_nxt = 24'hFF0000;
            3'd6:    pix_nxt = 24'h0000FF;
            default: pix_nxt = 24'h000000;
          endcase
        end
        2'd1:    pix_nxt = {3{nh[7:0]}};
        2'd2:    pix_nxt = (nh[5] ^ nv[5]) ? 24'h000000 : 24'hFFFFFF;
        default: pix_nxt = 24'h808080;
      endcase
    end
  end

  // divider, counters and registered outputs; I_EN low behaves like reset
  always_ff @(posedge I_CLK_100 or posedge I_RST) begin
    if (I_RST) begin
      d             <= '0;
      first         <= 1'b1;
      pat_q         <= '0;
      O_X           <= '0;
      O_Y           <= '0;
      O_PIX_DATA    <= '0;
      O_DE          <= 1'b0;
      O_HSYNC       <= SYNC_OFF;
      O_VSYNC       <= SYNC_OFF;
      O_PCLK        <= 1'b0;
      O_FRAME_START <= 1'b0;
    end else if (!I_EN) begin
      d             <= '0;
      first         <= 1'b1;
      pat_q         <= '0;
      O_X           <= '0;
      O_Y           <= '0;
      O_PIX_DATA    <= '0;
      O_DE          <= 1'b0;
      O_HSYNC       <= SYNC_OFF;
      O_VSYNC       <= SYNC_OFF;
      O_PCLK        <= 1'b0;
      O_FRAME_START <= 1'b0;
    end else begin
      d             <= d_nxt;
      // pclk rises mid-pixel so data has half a period of setup and hold
      O_PCLK        <= (d_nxt >= D_HALF);
      O_FRAME_START <= tick && origin;
      if (tick) begin
        first      <= 1'b0;
        pat_q      <= pat_nxt;
        O_X        <= nh;
        O_Y        <= nv;
        O_PIX_DATA <= pix_nxt;
        O_DE       <= de_nxt;
        O_HSYNC    <= hs_nxt;
        O_VSYNC    <= vs_nxt;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: a default-size instance (a) for line timing, bars and
// enable, a mid-size instance (b) for checker/grey/frame behaviour, and the
// tiny 12x7 instance (c) for async reset and full-frame timing.
module tb_vga_pattern_gen;

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic rst_a, en_a; logic [1:0] pat_a; logic [23:0] pix_a;
  logic vs_a, hs_a, de_a, pclk_a, fs_a; logic [9:0] x_a, y_a;
  logic rst_b, en_b; logic [1:0] pat_b; logic [23:0] pix_b;
  logic vs_b, hs_b, de_b, pclk_b, fs_b; logic [9:0] x_b, y_b;
  logic rst_c, en_c; logic [1:0] pat_c; logic [23:0] pix_c;
  logic vs_c, hs_c, de_c, pclk_c, fs_c; logic [9:0] x_c, y_c;

  int errors = 0;
  int checks = 0;

  vga_pattern_gen u_a (
    .I_CLK_100(clk_100), .I_RST(rst_a), .I_EN(en_a), .I_PATTERN(pat_a),
    .O_PIX_DATA(pix_a), .O_VSYNC(vs_a), .O_HSYNC(hs_a), .O_DE(de_a),
    .O_PCLK(pclk_a), .O_X(x_a), .O_Y(y_a), .O_FRAME_START(fs_a));

  vga_pattern_gen #(
    .CLK_DIV(2), .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(40), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_b (
    .I_CLK_100(clk_100), .I_RST(rst_b), .I_EN(en_b), .I_PATTERN(pat_b),
    .O_PIX_DATA(pix_b), .O_VSYNC(vs_b), .O_HSYNC(hs_b), .O_DE(de_b),
    .O_PCLK(pclk_b), .O_X(x_b), .O_Y(y_b), .O_FRAME_START(fs_b));

  vga_pattern_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_c (
    .I_CLK_100(clk_100), .I_RST(rst_c), .I_EN(en_c), .I_PATTERN(pat_c),
    .O_PIX_DATA(pix_c), .O_VSYNC(vs_c), .O_HSYNC(hs_c), .O_DE(de_c),
    .O_PCLK(pclk_c), .O_X(x_c), .O_Y(y_c), .O_FRAME_START(fs_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_100);
  endtask

  function automatic logic [9:0] gx(input int s);
    case (s)
      0:       return x_a;
      1:       return x_b;
      default: return x_c;
    endcase
  endfunction

  function automatic logic [9:0] gy(input int s);
    case (s)
      0:       return y_a;
      1:       return y_b;
      default: return y_c;
    endcase
  endfunction

  // advance to the first cycle at which instance s presents (x,y)
  task automatic adv(input int s, input int x, input int y, input string tag);
    int n = 0;
    while (!(gx(s) == 10'(x) && gy(s) == 10'(y)) && n < 20000) begin
      @(negedge clk_100);
      n++;
    end
    chk({"reach_", tag}, 32'(n < 20000), 32'd1);
  endtask

  initial begin
    int n;
    int dc;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    en_a = 1'b1;  en_b = 1'b1;  en_c = 1'b1;
    pat_a = 2'd0; pat_b = 2'd2; pat_c = 2'd0;
    step(3);

    // reset state
    chk("rst_pix",  32'(pix_a),  32'd0);
    chk("rst_de",   32'(de_a),   32'd0);
    chk("rst_hs",   32'(hs_a),   32'd1);
    chk("rst_vs",   32'(vs_a),   32'd1);
    chk("rst_pclk", 32'(pclk_a), 32'd0);
    chk("rst_x",    32'(x_a),    32'd0);
    chk("rst_y",    32'(y_a),    32'd0);
    chk("rst_fs",   32'(fs_a),   32'd0);

    // first pixel latency: 4 core cycles after release
    rst_a = 1'b0;
    step(1); chk("pclk_e1", 32'(pclk_a), 32'd0);
    step(1); chk("pclk_e2", 32'(pclk_a), 32'd1);
    step(1); chk("de_e3",   32'(de_a),   32'd0);
             chk("fs_e3",   32'(fs_a),   32'd0);
    step(1); chk("de_e4",   32'(de_a),   32'd1);
             chk("x_e4",    32'(x_a),    32'd0);
             chk("y_e4",    32'(y_a),    32'd0);
             chk("fs_e4",   32'(fs_a),   32'd1);
             chk("pix_e4",  32'(pix_a),  32'hFFFFFF);
             chk("pclk_e4", 32'(pclk_a), 32'd0);
    step(1); chk("fs_e5",   32'(fs_a),   32'd0);
             chk("x_e5",    32'(x_a),    32'd0);

    // colour bars and horizontal timing on line 0
    adv(0, 79, 0, "a79");   chk("bar79",  32'(pix_a), 32'hFFFFFF);
    adv(0, 80, 0, "a80");   chk("bar80",  32'(pix_a), 32'hFFFF00);
    adv(0, 560, 0, "a560"); chk("bar560", 32'(pix_a), 32'h000000);
                            chk("de560",  32'(de_a),  32'd1);
    adv(0, 640, 0, "a640"); chk("de640",  32'(de_a),  32'd0);
                            chk("pix640", 32'(pix_a), 32'd0);
    adv(0, 655, 0, "a655"); chk("hs655",  32'(hs_a),  32'd1);
    adv(0, 656, 0, "a656"); chk("hs656",  32'(hs_a),  32'd0);
    n = 0;
    while (hs_a == 1'b0 && n < 2000) begin step(1); n++; end
    chk("hs_low_cycles", 32'(n),   32'd384);
    chk("hs_end_x",      32'(x_a), 32'd752);
    chk("vs_line0",      32'(vs_a), 32'd1);

    adv(0, 0, 1, "a_l1");
    n = 0;
    while (de_a == 1'b1 && n < 5000) begin step(1); n++; end
    chk("de_high_cycles", 32'(n),   32'd2560);
    chk("de_end_x",       32'(x_a), 32'd640);

    // enable drop mid-line, then restart with a new pattern
    adv(0, 300, 2, "a300");
    en_a = 1'b0; pat_a = 2'd3;
    step(1); chk("en0_x",  32'(x_a),   32'd0);
             chk("en0_y",  32'(y_a),   32'd0);
             chk("en0_de", 32'(de_a),  32'd0);
             chk("en0_pix",32'(pix_a), 32'd0);
             chk("en0_hs", 32'(hs_a),  32'd1);
             chk("en0_pclk",32'(pclk_a),32'd0);
    step(9); chk("en0_hold_de", 32'(de_a), 32'd0);
    en_a = 1'b1;
    step(3); chk("ren_e3_de", 32'(de_a), 32'd0);
    step(1); chk("ren_e4_de", 32'(de_a), 32'd1);
             chk("ren_e4_x",  32'(x_a),  32'd0);
             chk("ren_e4_y",  32'(y_a),  32'd0);
             chk("ren_e4_fs", 32'(fs_a), 32'd1);
             chk("solid",     32'(pix_a), 32'h808080);
    pat_a = 2'd0;
    adv(0, 100, 0, "a100"); chk("no_tear", 32'(pix_a), 32'h808080);

    // checkerboard on mid-size instance
    rst_b = 1'b0;
    step(1); chk("b_e1_de", 32'(de_b), 32'd0);
    step(1); chk("b_e2_fs", 32'(fs_b), 32'd1);
             chk("b_00",    32'(pix_b), 32'hFFFFFF);
    adv(1, 31, 0, "b31");    chk("b_31_0",  32'(pix_b), 32'hFFFFFF);
    adv(1, 32, 0, "b32");    chk("b_32_0",  32'(pix_b), 32'h000000);
    adv(1, 0, 32, "b0_32");  chk("b_0_32",  32'(pix_b), 32'h000000);
    adv(1, 32, 32, "b32_32");chk("b_32_32", 32'(pix_b), 32'hFFFFFF);
    pat_b = 2'd1;
    adv(1, 5, 35, "b5_35");  chk("b_keep",  32'(pix_b), 32'h000000);
    adv(1, 40, 35, "b40");   chk("b_blank", 32'(pix_b), 32'd0);
    adv(1, 0, 40, "bv40");   chk("b_vs40",  32'(vs_b),  32'd1);
    adv(1, 0, 41, "bv41");   chk("b_vs41",  32'(vs_b),  32'd0);
    adv(1, 47, 42, "bv42");  chk("b_vs42",  32'(vs_b),  32'd0);
    adv(1, 0, 43, "bv43");   chk("b_vs43",  32'(vs_b),  32'd1);
    adv(1, 0, 0, "bf2");     chk("b_f2_fs", 32'(fs_b),  32'd1);
                             chk("b_grey0", 32'(pix_b), 32'h000000);
    n = 0;
    do begin step(1); n++; end while (!fs_b && n < 6000);
    chk("b_frame_cycles", 32'(n), 32'd4224);
    adv(1, 37, 0, "b37");    chk("b_grey37", 32'(pix_b), 32'h252525);

    // tiny instance: async reset mid-line and full 12x7 frame
    rst_c = 1'b0;
    adv(2, 5, 1, "c5_1");
    @(posedge clk_100);
    #2 rst_c = 1'b1;
    #1;
    chk("c_arst_x",  32'(x_c),  32'd0);
    chk("c_arst_y",  32'(y_c),  32'd0);
    chk("c_arst_de", 32'(de_c), 32'd0);
    chk("c_arst_hs", 32'(hs_c), 32'd1);
    @(negedge clk_100);
    rst_c = 1'b0;
    step(1); chk("c_e1_de", 32'(de_c), 32'd0);
    step(1); chk("c_e2_fs", 32'(fs_c), 32'd1);
             chk("c_e2_x",  32'(x_c),  32'd0);
             chk("c_e2_de", 32'(de_c), 32'd1);
    n = 0; dc = 0;
    do begin
      if (de_c) dc++;
      step(1); n++;
    end while (!fs_c && n < 1000);
    chk("c_frame_cycles", 32'(n),  32'd168);
    chk("c_de_cycles",    32'(dc), 32'd64);
    adv(2, 9, 0, "c9");   chk("c_hs9",  32'(hs_c), 32'd0);
    adv(2, 11, 0, "c11"); chk("c_hs11", 32'(hs_c), 32'd1);
    adv(2, 0, 5, "cv5");  chk("c_vs5",  32'(vs_c), 32'd0);
    adv(2, 0, 6, "cv6");  chk("c_vs6",  32'(vs_c), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
# vga_pattern_gen

Synthetic 640x480@60 video source that sits directly upstream of `edge_detection_top`. It drives that block's `I_PIX_DATA`, `I_VSYNC`, `I_HSYNC`, `I_DE` and `I_PCLK` inputs from the 100 MHz core clock. It derives a pixel-rate strobe, runs horizontal and vertical timing counters, and emits a selectable test pattern. This gives simulation and board bring-up a deterministic stimulus without an external video source.

## Interface
- `CLK_DIV`, 4: core clocks per pixel; even, ≥2.
- `H_ACTIVE`, 640: active pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: hsync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: active lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vsync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `SYNC_POL`, 0: asserted level of both syncs (0 = active-low).

Ports:
- `I_CLK_100`  in  1: core clock, the only clock.
- `I_RST`  in  1: reset; asynchronous, active-high.
- `I_EN`  in  1: run enable; low holds the generator idle.
- `I_PATTERN`  in  2: pattern select.
- `O_PIX_DATA`  out  24: RGB pixel, {R,G,B} 8 bits each.
- `O_VSYNC`  out  1: vertical sync.
- `O_HSYNC`  out  1: horizontal sync.
- `O_DE`  out  1: data enable, high in the active region.
- `O_PCLK`  out  1: pixel clock, 25 MHz at default parameters.
- `O_X`  out  10: current horizontal count h.
- `O_Y`  out  10: current vertical count v.
- `O_FRAME_START`  out  1: one-core-cycle pulse at pixel (0,0).

## Operation
- **Divider:** d counts 0..CLK_DIV-1 while `I_EN`=1, wrapping to 0. A pixel tick occurs when d=CLK_DIV-1.
- **Counters:**
  - h counts 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters = 800. h advances on each tick.
  - v counts 0..V_TOTAL-1 (525). v advances on each tick where h wraps.
  - v wraps to 0 after V_TOTAL-1.
- **Decode:** all decode is computed from the next (h,v) and registered on the tick edge.
  - DE = h<H_ACTIVE && v<V_ACTIVE.
  - HSYNC is asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - VSYNC is asserted for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], for whole lines.
- **Patterns:**
  - Pattern select is latched into an internal register only when the next position is (0,0), so there is no mid-frame tearing.
  - 0: color bars, 80-px bars by x/80, in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - 1: grey ramp, R=G=B=x[7:0].
  - 2: 32x32 checkerboard; FFFFFF when x[5]^y[5]=0, else 000000.
  - 3: solid 808080.
  - `O_PIX_DATA` is 000000 whenever DE=0.
- **`I_EN`:**
  - `I_EN`=0 forces d=h=v=0 and all outputs to their reset values, on the next core edge.
  - On re-enable, the first tick presents (0,0) with a new pattern latch.
  - Deassertion mid-frame aborts that frame immediately.

## Timing
- **Reset values** (asynchronous): `O_PIX_DATA`=0, `O_DE`=0, `O_HSYNC`=`O_VSYNC`=~SYNC_POL (1 at default), `O_PCLK`=0, `O_X`=`O_Y`=0, `O_FRAME_START`=0. The latched pattern is 0; d=h=v=0.
- **Output update:** all pixel outputs update together on the core edge where d goes CLK_DIV-1→0, and hold for CLK_DIV cycles.
- **`O_PCLK`:** registered, equal to (d ≥ CLK_DIV/2), giving a 50% duty cycle. Its rising edge falls mid-period, so data has CLK_DIV/2 core cycles of setup and hold.
- **Latency:** the first tick after reset release with `I_EN`=1 occurs CLK_DIV core cycles later and presents (0,0).
  - `O_FRAME_START` pulses high for exactly one core cycle, coincident with that update and with every later (0,0) update.
- **Period:** line = H_TOTAL×CLK_DIV = 3200 core cycles; frame = 1,680,000 core cycles.
- **Counter widths:** fixed at 10 bits; parameters must keep H_TOTAL and V_TOTAL ≤ 1024.
- **Reset mid-line:** all state and outputs clear asynchronously at once. Restart follows the latency rule above.

## Test plan
- Reset then `I_EN`=1 at defaults → all outputs hold reset values during reset. Exactly 4 cycles after release, `O_DE`=1, `O_X`=0, `O_Y`=0 and `O_FRAME_START` pulses for 1 cycle.
- Line timing → per line, `O_DE` high 2560 cycles; `O_HSYNC` low 384 cycles starting at `O_X`=656; `O_PCLK` period 4 with duty 2/2. Consecutive `O_FRAME_START` pulses are 1,680,000 cycles apart; `O_VSYNC` low only for `O_Y`=490..491.
- `I_PATTERN`=0 → (79,0)=FFFFFF, (80,0)=FFFF00, (639,479)=000000. Pattern 2 → (0,0)=FFFFFF, (32,0)=000000, (32,32)=FFFFFF. Pattern 3 → 808080. With `O_DE`=0, data=000000.
- `I_PATTERN` 0→2 at `O_Y`=100 → pattern-0 output continues to end of frame; pattern 2 appears from the next (0,0).
- `I_EN` dropped at `O_X`=300, `O_Y`=200, held 10 cycles, then reasserted → next core edge gives reset values. Restart gives (0,0) after 4 cycles with an `O_FRAME_START` pulse.
- Small parameters (H 8/1/2/1, V 4/1/1/1, CLK_DIV=2) with `I_RST` pulsed mid-line → immediate async clear, then correct 12×7 timing from (0,0).
